// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan decoder: segment patterns and scan FSM states.
`default_nettype none

package ssd_pkg;

  // Active-low segment patterns, bit 0 = a ... bit 6 = g
  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;
  localparam logic [0:6] SEG_A     = 7'b0001000;
  localparam logic [0:6] SEG_B     = 7'b1100000;
  localparam logic [0:6] SEG_C     = 7'b0110001;
  localparam logic [0:6] SEG_D     = 7'b1000010;
  localparam logic [0:6] SEG_E     = 7'b0110000;
  localparam logic [0:6] SEG_F     = 7'b0111000;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_DASH  = 7'b1111110;

  localparam logic [0:6] SEG_HEX [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };

  typedef enum logic [1:0] {
    WAIT_SEL = 2'd0,
    SETTLE   = 2'd1,
    HOLD     = 2'd2
  } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/ssd_pattern_decode.sv
// Maps one active-low segment pattern to its hex nibble, blank flag and error flag.
`default_nettype none

module ssd_pattern_decode
  import ssd_pkg::*;
(
  input  logic [0:6] seg_n,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err
);

  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    err    = 1'b1;
    if (seg_n == SEG_BLANK) begin
      blank = 1'b1;
      err   = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (seg_n == SEG_HEX[i]) begin
          nibble = 4'(i);
          err    = 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ssd_scan_decoder.sv
// Recovers a full frame of hex digits from a multiplexed seven-segment display bus,
// sampling each digit only once its select and segment lines have settled.
`default_nettype none

module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [0:6]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] frame_data,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    frame_err,
  output logic                    frame_valid
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int RW = NUM_DIGITS + 7;

  scan_state_t state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [RW-1:0] sel_ref_q, sel_ref_d;
  logic [RW-1:0] cur;
  logic [3:0]   n_low;
  logic [IW-1:0] sel_idx;
  logic         sel_valid;
  logic         load;
  logic         sample;
  logic         frame_done;

  logic [4*NUM_DIGITS-1:0] work_nib;
  logic [NUM_DIGITS-1:0]   work_blank;
  logic [NUM_DIGITS-1:0]   work_err, work_err_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;

  logic [3:0] dec_nibble;
  logic       dec_blank;
  logic       dec_err;

  ssd_pattern_decode u_decode (
    .seg_n  (seg_n),
    .nibble (dec_nibble),
    .blank  (dec_blank),
    .err    (dec_err)
  );

  assign cur = {an_n, seg_n};

  // Count low select lines and remember which one; valid only when exactly one is low.
  always_comb begin
    n_low   = 4'd0;
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_n[i]) begin
        n_low   = n_low + 4'd1;
        sel_idx = IW'(i);
      end
    end
  end

  assign sel_valid  = (n_low == 4'd1);
  assign frame_done = &mask_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_ref_d = sel_ref_q;
    load      = 1'b0;
    sample    = 1'b0;
    case (state_q)
      WAIT_SEL: load = sel_valid;
      SETTLE: begin
        if (!sel_valid) begin
          state_d = WAIT_SEL;
        end else if (cur != sel_ref_q) begin
          load = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == 8'(STABLE_CYCLES)) begin
            sample  = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (cur != sel_ref_q) begin
          if (sel_valid) load = 1'b1;
          else           state_d = WAIT_SEL;
        end
      end
      default: state_d = WAIT_SEL;
    endcase
    // A fresh selection restarts the settle count; a single-cycle requirement samples at once.
    if (load) begin
      sel_ref_d = cur;
      cnt_d     = 8'd1;
      if (STABLE_CYCLES == 1) begin
        sample  = 1'b1;
        state_d = HOLD;
      end else begin
        state_d = SETTLE;
      end
    end
  end

  // Frame hand-off clears the mask first so a same-cycle sample lands in the new frame.
  always_comb begin
    mask_d     = mask_q;
    work_err_d = work_err;
    if (frame_done) begin
      mask_d     = '0;
      work_err_d = '0;
    end
    if (sample) begin
      mask_d[sel_idx]     = 1'b1;
      work_err_d[sel_idx] = dec_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_SEL;
      cnt_q       <= 8'd0;
      sel_ref_q   <= '0;
      mask_q      <= '0;
      work_nib    <= '0;
      work_blank  <= '0;
      work_err    <= '0;
      frame_data  <= '0;
      blank_mask  <= '0;
      frame_err   <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_ref_q   <= sel_ref_d;
      mask_q      <= mask_d;
      work_err    <= work_err_d;
      frame_valid <= frame_done;
      if (sample) begin
        work_nib[{sel_idx, 2'b00} +: 4] <= dec_nibble;
        work_blank[sel_idx]             <= dec_blank;
      end
      if (frame_done) begin
        frame_data <= work_nib;
        blank_mask <= work_blank;
        frame_err  <= |work_err;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ssd_scan_decoder.sv
// Self-checking bench: directed scan scenarios plus randomized scans against a run-length frame model.
`default_nettype none

module tb_ssd_scan_decoder;
  import ssd_pkg::*;

  localparam int STABLE = 4;
  localparam logic [0:6] PAT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  localparam logic [0:6] BLANK = 7'b1111111;
  localparam logic [0:6] DASH  = 7'b1111110;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [0:6]  seg_n = 7'b1111111;
  logic [7:0]  an_n  = 8'hFF;
  logic [31:0] frame_data;
  logic [7:0]  blank_mask;
  logic        frame_err;
  logic        frame_valid;

  logic [0:6]  seg1 = 7'b1111111;
  logic [3:0]  an1  = 4'hF;
  logic [15:0] fd1;
  logic [3:0]  bm1;
  logic        fe1;
  logic        fv1;

  int checks = 0;
  int failures = 0;
  int fv_seen = 0;
  logic [31:0] last_fd;
  logic [7:0]  last_bm;
  logic        last_fe;

  // reference model state
  logic [14:0] m_prev;
  int          m_run;
  logic [7:0]  m_mask;
  logic [3:0]  m_nib [8];
  logic        m_blank [8];
  logic        m_err [8];
  logic [31:0] m_fd;
  logic [7:0]  m_bm;
  logic        m_fe;
  logic        m_fv;

  always #5 clk = ~clk;

  ssd_scan_decoder #(.NUM_DIGITS(8), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n),
    .frame_data(frame_data), .blank_mask(blank_mask),
    .frame_err(frame_err), .frame_valid(frame_valid)
  );

  ssd_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(1)) dut_s1 (
    .clk(clk), .rst(rst), .seg_n(seg1), .an_n(an1),
    .frame_data(fd1), .blank_mask(bm1),
    .frame_err(fe1), .frame_valid(fv1)
  );

  function automatic logic [5:0] model_decode(input logic [0:6] s);
    if (s == BLANK) return 6'b0000_10;
    for (int k = 0; k < 16; k++)
      if (PAT[k] == s) return {4'(k), 2'b00};
    return 6'b0000_01;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_run = 0; m_mask = '0;
    m_fd = '0; m_bm = '0; m_fe = 1'b0; m_fv = 1'b0;
    for (int k = 0; k < 8; k++) begin
      m_nib[k] = 4'h0; m_blank[k] = 1'b0; m_err[k] = 1'b0;
    end
  endtask

  // A digit is sampled when a valid selection has been identical for exactly STABLE cycles.
  task automatic model_edge(input logic [0:6] s, input logic [7:0] a);
    logic [14:0] cur;
    logic [5:0]  dec;
    bit          valid;
    int          idx;
    cur   = {a, s};
    valid = ($countones(~a) == 1);
    idx   = 0;
    for (int k = 0; k < 8; k++) if (!a[k]) idx = k;
    if (!valid) m_run = 0;
    else if (m_run > 0 && cur == m_prev) m_run++;
    else m_run = 1;
    m_prev = cur;
    m_fv = 1'b0;
    if (m_mask == 8'hFF) begin
      m_fe = 1'b0;
      for (int k = 0; k < 8; k++) begin
        m_fd[4*k +: 4] = m_nib[k];
        m_bm[k] = m_blank[k];
        m_fe = m_fe | m_err[k];
        m_err[k] = 1'b0;
      end
      m_fv = 1'b1;
      m_mask = '0;
    end
    if (valid && m_run == STABLE) begin
      dec = model_decode(s);
      m_nib[idx] = dec[5:2]; m_blank[idx] = dec[1]; m_err[idx] = dec[0];
      m_mask[idx] = 1'b1;
    end
  endtask

  task automatic step(input logic [0:6] s, input logic [7:0] a);
    seg_n = s; an_n = a;
    @(posedge clk);
    model_edge(s, a);
    #1;
    checks++;
    if (frame_valid !== m_fv) begin
      failures++;
      $display("FAIL frame_valid t=%0t got=%b exp=%b", $time, frame_valid, m_fv);
    end
    if (frame_valid === 1'b1) begin
      fv_seen++; last_fd = frame_data; last_bm = blank_mask; last_fe = frame_err;
    end
    if (m_fv) begin
      checks++;
      if (frame_data !== m_fd || blank_mask !== m_bm || frame_err !== m_fe) begin
        failures++;
        $display("FAIL frame_contents t=%0t got=%h/%h/%b exp=%h/%h/%b",
                 $time, frame_data, blank_mask, frame_err, m_fd, m_bm, m_fe);
      end
    end
  endtask

  task automatic hold_digit(input int d, input logic [0:6] s, input int n);
    logic [7:0] a;
    a = 8'h01 << d;
    a = ~a;
    for (int k = 0; k < n; k++) step(s, a);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(BLANK, 8'hFF);
  endtask

  task automatic do_reset();
    seg_n = BLANK; an_n = 8'hFF; seg1 = BLANK; an1 = 4'hF;
    @(negedge clk);
    rst = 1'b1;
    #2;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_total(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic check_frame(input string name, input logic [31:0] fd, input logic [7:0] bm, input logic fe);
    checks++;
    if (last_fd !== fd || last_bm !== bm || last_fe !== fe) begin
      failures++;
      $display("FAIL %s got=%h/%h/%b exp=%h/%h/%b", name, last_fd, last_bm, last_fe, fd, bm, fe);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (frame_data !== 32'h0 || blank_mask !== 8'h0 || frame_err !== 1'b0 || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%h/%b/%b exp=0/0/0/0", frame_data, blank_mask, frame_err, frame_valid);
    end
  endtask

  task automatic test_hex_scan();
    int base;
    int vals [8] = '{3, 2, 1, 0, 15, 14, 13, 12};
    base = fv_seen;
    for (int d = 0; d < 8; d++) hold_digit(d, PAT[vals[d]], 6);
    idle(2);
    check_total("hex_scan_pulses", fv_seen - base, 1);
    check_frame("hex_scan_frame", 32'hCDEF0123, 8'h00, 1'b0);
  endtask

  task automatic test_error();
    int base;
    base = fv_seen;
    for (int d = 0; d < 8; d++) hold_digit(d, (d == 5) ? DASH : PAT[8], 6);
    idle(2);
    check_total("error_pulses", fv_seen - base, 1);
    check_frame("error_frame", 32'h88088888, 8'h00, 1'b1);
  endtask

  task automatic test_glitch();
    int base;
    base = fv_seen;
    hold_digit(0, PAT[0], 6);
    hold_digit(1, PAT[0], 6);
    for (int k = 0; k < 6; k++) hold_digit(2, (k % 2 == 0) ? PAT[0] : PAT[1], 2);
    for (int d = 3; d < 8; d++) hold_digit(d, PAT[0], 6);
    check_total("glitch_no_frame", fv_seen - base, 0);
    hold_digit(2, PAT[1], 6);
    idle(2);
    check_total("glitch_then_hold", fv_seen - base, 1);
    check_frame("glitch_frame", 32'h00000100, 8'h00, 1'b0);
  endtask

  task automatic test_multi_sel();
    int base;
    base = fv_seen;
    for (int d = 0; d < 7; d++) hold_digit(d, PAT[5], 5);
    for (int k = 0; k < 10; k++) step(PAT[5], 8'b11110011);
    checks++;
    if (dut.state_q !== WAIT_SEL) begin
      failures++;
      $display("FAIL multi_sel_state got=%0d exp=%0d", dut.state_q, WAIT_SEL);
    end
    check_total("multi_sel_no_frame", fv_seen - base, 0);
    hold_digit(7, PAT[9], 5);
    idle(2);
    check_total("multi_sel_resume", fv_seen - base, 1);
    check_frame("multi_sel_frame", 32'h95555555, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid();
    int base;
    for (int d = 0; d < 5; d++) hold_digit(d, PAT[7], 6);
    do_reset();
    checks++;
    if (frame_data !== 32'h0 || blank_mask !== 8'h0 || frame_err !== 1'b0 || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%h/%h/%b/%b exp=0/0/0/0", frame_data, blank_mask, frame_err, frame_valid);
    end
    base = fv_seen;
    for (int d = 5; d < 8; d++) hold_digit(d, PAT[10], 6);
    idle(2);
    check_total("reset_mid_no_stale_frame", fv_seen - base, 0);
    for (int d = 0; d < 5; d++) hold_digit(d, PAT[10], 6);
    idle(2);
    check_total("reset_mid_one_frame", fv_seen - base, 1);
    check_frame("reset_mid_frame", 32'hAAAAAAAA, 8'h00, 1'b0);
  endtask

  task automatic test_blank();
    int base;
    base = fv_seen;
    for (int d = 0; d < 8; d++) hold_digit(d, (d >= 6) ? BLANK : PAT[0], 6);
    idle(2);
    check_total("blank_pulses", fv_seen - base, 1);
    check_frame("blank_frame", 32'h00000000, 8'hC0, 1'b0);
  endtask

  task automatic test_random();
    logic [0:6] s;
    int         r;
    for (int round = 0; round < 10; round++) begin
      for (int d = 0; d < 8; d++) begin
        r = $urandom_range(0, 19);
        if (r < 16)       s = PAT[r];
        else if (r == 16) s = BLANK;
        else if (r == 17) s = DASH;
        else              s = 7'($urandom);
        if ($urandom_range(0, 7) == 0) step(s, 8'($urandom));
        hold_digit(d, s, $urandom_range(1, 7));
      end
    end
    idle(3);
  endtask

  // Single-cycle settle: every scan cycle samples, so frames arrive back to back.
  task automatic test_back_to_back();
    logic [15:0] exp_fd [4];
    int          got;
    got = 0;
    for (int r = 0; r < 4; r++)
      for (int d = 0; d < 4; d++) exp_fd[r][4*d +: 4] = 4'((r * 4 + d) % 16);
    for (int c = 0; c < 17; c++) begin
      if (c < 16) begin
        logic [3:0] a;
        a = 4'h1 << (c % 4);
        an1 = ~a;
        seg1 = PAT[c % 16];
      end else begin
        an1 = 4'hF;
        seg1 = BLANK;
      end
      step(BLANK, 8'hFF);
      if (fv1 === 1'b1) begin
        checks++;
        if (got < 4 && (fd1 !== exp_fd[got] || bm1 !== 4'h0 || fe1 !== 1'b0)) begin
          failures++;
          $display("FAIL b2b_frame%0d got=%h/%h/%b exp=%h/0/0", got, fd1, bm1, fe1, exp_fd[got]);
        end
        got++;
      end
    end
    check_total("b2b_frame_count", got, 4);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_hex_scan();
    test_error();
    test_glitch();
    test_multi_sel();
    test_blank();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
